soc_system_limit_sw_in: RTL and testbench
=========================================

Name: soc_system_limit_sw_in

Overview:
- Avalon-MM slave input port, the read-side counterpart of the single-bit motor direction/enable output PIOs on the HPS lightweight bridge.
- Samples external limit-switch/bumper inputs: 2-flop synchroniser, then a per-bit debouncer with a programmable period.
- Reports debounced levels, per-bit edge capture and a maskable level interrupt to the HPS.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- CNT_W, 16, debounce counter/period register width (1..32).
- DB_DEFAULT, 50000, reset value of the debounce period in clk cycles (1 ms at 50 MHz).
- EDGE_TYPE, 2, edges captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon chip select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- in_port  in  WIDTH  raw asynchronous switch inputs.
- readdata  out  32  Avalon read data, combinational, read latency 0.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Interface decisions: one clock domain (clk); reset is asynchronous and active-low on reset_n. All flops clear on reset_n low, independent of clk.
- Register map, unused upper bits read 0:
  - 0 DATA, RO: debounced levels [WIDTH-1:0].
  - 1 PERIOD, RW: debounce period [CNT_W-1:0].
  - 2 IRQMASK, RW: [WIDTH-1:0].
  - 3 EDGECAP, W1C: [WIDTH-1:0].
- Write qualifier: chipselect && !write_n. Writes to DATA are ignored.
- Reset values: sync stages 0, stable 0, counters 0, PERIOD = DB_DEFAULT, IRQMASK 0, EDGECAP 0, irq 0, readdata = 0 for address 0.
- Synchroniser: s1 <= in_port; s2 <= s1. s2 is valid 2 edges after an in_port change.
- Debouncer, per bit i:
  - If s2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] >= PERIOD-1: stable[i] <= s2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- PERIOD 0 and 1 behave identically: stable follows s2 one edge later.
- Total latency: a change before edge k appears in DATA after edge k+1+max(PERIOD,1).
- A glitch shorter than PERIOD consecutive mismatching s2 samples is rejected; its counter returns to 0.
- PERIOD written mid-count takes effect on the next compare. If cnt is already >= the new PERIOD-1, stable updates on the next edge.
- Edge capture: at the edge where stable[i] updates, EDGECAP[i] <= 1 if the transition matches EDGE_TYPE.
- EDGECAP clear: a write to address 3 clears each bit where writedata[i] = 1.
  - Same-edge set and clear on one bit: set wins.
  - Bits written 0 are untouched.
- irq = |(EDGECAP & IRQMASK), driven from registers, no combinational path from the bus. It stays high until the capture bit is cleared or masked.
- readdata: combinational mux on address, zero-extended. Reads have no side effects.
- Reset mid-debounce: counters and stable return to 0. An input held high after reset release is re-debounced from scratch and produces a rising capture.

Decomposition:
- Shared package (soc_system_pio_pkg): register address constants ADDR_DATA=0, ADDR_PERIOD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3, and EDGE_TYPE encodings. The output PIOs reuse the address constants.
- One sub-module, soc_system_debounce_bit: per-bit synchroniser, counter and stable flop, with an edge-pulse output. It is instantiated WIDTH times in a generate loop. Top level holds the registers, capture logic and Avalon mux.

Test Plan:
- Reset: reset_n low 3 cycles with in_port=4'hF -> PERIOD reads 50000, DATA/IRQMASK/EDGECAP read 0, irq=0.
- Glitch reject: PERIOD=4, in_port[0] high for 3 cycles then low -> DATA stays 0, EDGECAP stays 0.
- Accept and latency: PERIOD=4, in_port[0] rises before edge k and stays high -> DATA=1 after edge k+5, EDGECAP=1 at the same edge, irq stays 0 (mask 0).
- IRQ and W1C: IRQMASK=4'h1 with EDGECAP[0]=1 -> irq=1. Write EDGECAP=4'h1 -> irq=0 next cycle. Write 4'h2 -> EDGECAP[0] unaffected.
- Set/clear collision: schedule the W1C write on the exact edge where bit 1 debounces -> EDGECAP[1]=1 afterwards.
- Bypass and reset mid-count: PERIOD=0 -> DATA follows in_port after 3 edges. Then PERIOD=100, drive bit 2 high, assert reset_n at count 50 -> after release DATA[2]=0 until 100 more stable cycles.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared register map and edge-select encodings for the HPS lightweight-bridge
// PIO blocks. The output PIOs use the same address constants.
package soc_system_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_PERIOD  = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   typedef struct packed {
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wdata;
   } pio_req_t;

   function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
      case (edge_type)
         EDGE_RISE: return rise;
         EDGE_FALL: return fall;
         default:   return rise | fall;
      endcase
   endfunction

endpackage

// File: rtl/soc_system_debounce_bit.sv
// One input bit: two-flop synchroniser, mismatch counter and debounced level.
// rise/fall pulse during the cycle whose closing edge updates the stable level.
module soc_system_debounce_bit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic [CNT_W-1:0] period,
   output logic             stable,
   output logic             rise,
   output logic             fall
);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;
   logic             upd;

   always_comb begin
      s1_d     = din;
      s2_d     = s1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      upd      = 1'b0;
      // cnt+1 >= period is cnt >= period-1 without the underflow at period 0
      cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_inc >= {1'b0, period}) begin
         stable_d = s2_q;
         cnt_d    = '0;
         upd      = 1'b1;
      end else begin
         cnt_d = cnt_inc[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign rise   = upd & s2_q;
   assign fall   = upd & ~s2_q;

endmodule

// File: rtl/soc_system_limit_sw_in.sv
// Avalon-MM input PIO for limit switches/bumpers: debounced levels, per-bit
// edge capture (write-1-to-clear) and a maskable level interrupt.
module soc_system_limit_sw_in
   import soc_system_pio_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int CNT_W      = 16,
   parameter int DB_DEFAULT = 50000,
   parameter int EDGE_TYPE  = EDGE_ANY
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DB_DEFAULT);

   pio_req_t         req;
   logic [WIDTH-1:0] stable, rise, fall, cap_set, clr;
   logic [CNT_W-1:0] period_q, period_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic             unused_wdata;

   always_comb begin
      req.addr  = address;
      req.wr    = chipselect & ~write_n;
      req.wdata = writedata;
   end

   // write data bits above WIDTH/CNT_W carry no meaning
   assign unused_wdata = ^req.wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      soc_system_debounce_bit #(.CNT_W(CNT_W)) u_db (
         .clk    (clk),
         .rst_n  (reset_n),
         .din    (in_port[i]),
         .period (period_q),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
      assign cap_set[i] = edge_hit(EDGE_TYPE, rise[i], fall[i]);
   end

   always_comb begin
      period_d  = period_q;
      irqmask_d = irqmask_q;
      clr       = '0;
      if (req.wr) begin
         case (req.addr)
            ADDR_PERIOD:  period_d  = req.wdata[CNT_W-1:0];
            ADDR_IRQMASK: irqmask_d = req.wdata[WIDTH-1:0];
            ADDR_EDGECAP: clr       = req.wdata[WIDTH-1:0];
            default:      ;
         endcase
      end
      // a capture landing on the same edge as its clear must survive
      edgecap_d = (edgecap_q & ~clr) | cap_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_q  <= PERIOD_RST;
         irqmask_q <= '0;
         edgecap_q <= '0;
      end else begin
         period_q  <= period_d;
         irqmask_q <= irqmask_d;
         edgecap_q <= edgecap_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata = 32'(stable);
         ADDR_PERIOD:  readdata = 32'(period_q);
         ADDR_IRQMASK: readdata = 32'(irqmask_q);
         ADDR_EDGECAP: readdata = 32'(edgecap_q);
         default:      readdata = '0;
      endcase
   end

   assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_limit_sw_in.sv
// Directed bench for soc_system_limit_sw_in: table vectors for reset and
// bypass behaviour, hand sequences for glitch, latency, W1C, collision, reset.
module tb_soc_system_limit_sw_in;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  wa;
      logic [31:0] wd;
      logic [3:0]  inp;
      int          ticks;
      logic [1:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t rv[5];
   vec_t bv[9];

   soc_system_limit_sw_in dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(name, readdata, exp);
   endtask

   task automatic apply(input string name, input vec_t v);
      in_port = v.inp;
      if (v.wr) bus_wr(v.wa, v.wd);
      repeat (v.ticks) tick();
      rd_chk({name, "_rd"}, v.ra, v.exp_rd);
      chk({name, "_irq"}, {31'd0, irq}, {31'd0, v.exp_irq});
   endtask

   initial begin
      // wr, wa, wd, inp, ticks, ra, exp_rd, exp_irq
      rv[0] = '{1'b0, 2'd0, 32'd0, 4'hF, 0, 2'd1, 32'd50000, 1'b0};
      rv[1] = '{1'b0, 2'd0, 32'd0, 4'hF, 0, 2'd0, 32'd0,     1'b0};
      rv[2] = '{1'b0, 2'd0, 32'd0, 4'hF, 0, 2'd2, 32'd0,     1'b0};
      rv[3] = '{1'b0, 2'd0, 32'd0, 4'hF, 0, 2'd3, 32'd0,     1'b0};
      rv[4] = '{1'b0, 2'd0, 32'd0, 4'hF, 1, 2'd0, 32'd0,     1'b0};

      // starts with DATA=3, EDGECAP=0, IRQMASK=1
      bv[0] = '{1'b1, 2'd1, 32'd0,   4'h3, 0, 2'd1, 32'd0,   1'b0};
      bv[1] = '{1'b0, 2'd0, 32'd0,   4'h5, 2, 2'd0, 32'h3,   1'b0};
      bv[2] = '{1'b0, 2'd0, 32'd0,   4'h5, 1, 2'd0, 32'h5,   1'b0};
      bv[3] = '{1'b0, 2'd0, 32'd0,   4'hA, 3, 2'd0, 32'hA,   1'b1};
      bv[4] = '{1'b1, 2'd1, 32'd1,   4'hA, 0, 2'd1, 32'd1,   1'b1};
      bv[5] = '{1'b0, 2'd0, 32'd0,   4'h0, 2, 2'd0, 32'hA,   1'b1};
      bv[6] = '{1'b0, 2'd0, 32'd0,   4'h0, 1, 2'd0, 32'h0,   1'b1};
      bv[7] = '{1'b0, 2'd0, 32'd0,   4'h0, 0, 2'd3, 32'hF,   1'b1};
      bv[8] = '{1'b1, 2'd3, 32'hF,   4'h0, 0, 2'd3, 32'h0,   1'b0};

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      repeat (3) tick();
      for (int i = 0; i < 5; i++) apply($sformatf("rst%0d", i), rv[i]);
      in_port = 4'h0;
      tick();
      reset_n = 1'b1;
      tick();

      // glitch of 3 samples against PERIOD=4
      bus_wr(2'd1, 32'd4);
      rd_chk("period_rb", 2'd1, 32'd4);
      in_port = 4'h1;
      repeat (3) tick();
      in_port = 4'h0;
      repeat (8) tick();
      rd_chk("glitch_data", 2'd0, 32'd0);
      rd_chk("glitch_cap", 2'd3, 32'd0);

      // accept: change before edge k visible after edge k+5
      in_port = 4'h1;
      repeat (5) tick();
      rd_chk("early_data", 2'd0, 32'd0);
      rd_chk("early_cap", 2'd3, 32'd0);
      tick();
      rd_chk("acc_data", 2'd0, 32'd1);
      rd_chk("acc_cap", 2'd3, 32'd1);
      chk("acc_irq_masked", {31'd0, irq}, 32'd0);

      // interrupt and write-1-to-clear
      bus_wr(2'd2, 32'h1);
      chk("irq_on", {31'd0, irq}, 32'd1);
      bus_wr(2'd3, 32'h2);
      rd_chk("w1c_other", 2'd3, 32'd1);
      chk("irq_still", {31'd0, irq}, 32'd1);
      bus_wr(2'd3, 32'h1);
      rd_chk("w1c_clr", 2'd3, 32'd0);
      chk("irq_off", {31'd0, irq}, 32'd0);

      // clear of bit 1 lands on the same edge that debounces it
      in_port = 4'h3;
      repeat (5) tick();
      rd_chk("coll_pre", 2'd3, 32'd0);
      bus_wr(2'd3, 32'h2);
      rd_chk("coll_data", 2'd0, 32'h3);
      rd_chk("coll_cap", 2'd3, 32'h2);
      chk("coll_irq", {31'd0, irq}, 32'd0);
      bus_wr(2'd3, 32'h2);
      rd_chk("coll_clr", 2'd3, 32'h0);

      for (int i = 0; i < 9; i++) apply($sformatf("byp%0d", i), bv[i]);

      // reset while bit 2 is 50 counts into a 100-cycle debounce
      bus_wr(2'd1, 32'd100);
      in_port = 4'h4;
      repeat (50) tick();
      rd_chk("mid_data", 2'd0, 32'h0);
      reset_n = 1'b0;
      #1;
      rd_chk("mid_rst_period", 2'd1, 32'd50000);
      tick();
      tick();
      reset_n = 1'b1;
      bus_wr(2'd1, 32'd100);
      rd_chk("post_cap", 2'd3, 32'h0);
      repeat (100) tick();
      rd_chk("post_early", 2'd0, 32'h0);
      tick();
      rd_chk("post_data", 2'd0, 32'h4);
      rd_chk("post_cap_rise", 2'd3, 32'h4);
      chk("post_irq", {31'd0, irq}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
